// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES registered segments,
// with a valid/ready handshake on both sides and carry/borrow, overflow and zero flags.
module addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cb,
    output logic             ovf,
    output logic             zero
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic             v_r    [STAGES];
    logic [WIDTH-1:0] a_r    [STAGES];
    logic [WIDTH-1:0] b_r    [STAGES];
    logic [WIDTH-1:0] res_r  [STAGES];
    logic             c_r    [STAGES];
    logic             op_r   [STAGES];
    logic             cb_r;
    logic             ovf_r;
    logic             zero_r;

    logic             v_in   [STAGES];
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] res_in [STAGES];
    logic [WIDTH-1:0] res_nx [STAGES];
    logic             c_in   [STAGES];
    logic             c_nx   [STAGES];
    logic             op_in  [STAGES];
    logic [SEG:0]     seg_sum;
    logic             msb_cin;
    logic             cb_nx;
    logic             ovf_nx;
    logic             zero_nx;
    logic             stall;

    assign stall    = v_r[LAST] && !out_ready;
    assign in_ready = !stall;

    // Stage 0 inverts B and injects op_sub as carry-in, turning a-b into a + ~b + 1.
    always_comb begin
        v_in[0]   = in_valid;
        a_in[0]   = a;
        b_in[0]   = op_sub ? ~b : b;
        c_in[0]   = op_sub;
        op_in[0]  = op_sub;
        res_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k]   = v_r[k-1];
            a_in[k]   = a_r[k-1];
            b_in[k]   = b_r[k-1];
            c_in[k]   = c_r[k-1];
            op_in[k]  = op_r[k-1];
            res_in[k] = res_r[k-1];
        end
        seg_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            seg_sum = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
                    + {{SEG{1'b0}}, c_in[k]};
            res_nx[k]              = res_in[k];
            res_nx[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
            c_nx[k]                = seg_sum[SEG];
        end
    end

    // The carry into the MSB is recovered from the MSB sum bit, so the segment adder needs no extra tap.
    always_comb begin
        msb_cin = res_nx[LAST][WIDTH-1] ^ a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1];
        cb_nx   = c_nx[LAST] ^ op_in[LAST];
        ovf_nx  = msb_cin ^ c_nx[LAST];
        zero_nx = ~|res_nx[LAST];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k]   <= 1'b0;
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                res_r[k] <= '0;
                c_r[k]   <= 1'b0;
                op_r[k]  <= 1'b0;
            end
            cb_r   <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k] <= v_in[k];
                if (v_in[k]) begin
                    a_r[k]   <= a_in[k];
                    b_r[k]   <= b_in[k];
                    res_r[k] <= res_nx[k];
                    c_r[k]   <= c_nx[k];
                    op_r[k]  <= op_in[k];
                end
            end
            if (v_in[LAST]) begin
                cb_r   <= cb_nx;
                ovf_r  <= ovf_nx;
                zero_r <= zero_nx;
            end
        end
    end

    assign out_valid = v_r[LAST];
    assign result    = res_r[LAST];
    assign cb        = cb_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed cases on the 16/2 configuration plus random traffic
// on 10/5 and 32/4 instances, all checked through per-instance expected-result queues.
module tb_addsub_pipe;
    localparam int N_RAND = 10000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 16-bit, 2-stage instance
    logic        d_in_valid = 1'b0, d_in_ready, d_op_sub = 1'b0, d_out_valid, d_out_ready = 1'b1;
    logic [15:0] d_a = '0, d_b = '0, d_result;
    logic        d_cb, d_ovf, d_zero;
    logic [18:0] d_exp = '0, d_e;
    logic [18:0] d_q[$];

    // 10-bit, 5-stage instance
    logic        r10_in_valid = 1'b0, r10_in_ready, r10_op_sub = 1'b0, r10_out_valid, r10_out_ready = 1'b1;
    logic [9:0]  r10_a = '0, r10_b = '0, r10_result;
    logic        r10_cb, r10_ovf, r10_zero;
    logic [34:0] r10_exp = '0, e10;
    logic [34:0] q10[$];
    int          recv10 = 0;

    // 32-bit, 4-stage instance
    logic        r32_in_valid = 1'b0, r32_in_ready, r32_op_sub = 1'b0, r32_out_valid, r32_out_ready = 1'b1;
    logic [31:0] r32_a = '0, r32_b = '0, r32_result;
    logic        r32_cb, r32_ovf, r32_zero;
    logic [34:0] r32_exp = '0, e32;
    logic [34:0] q32[$];
    int          recv32 = 0;

    addsub_pipe #(.WIDTH(16), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .op_sub(d_op_sub), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .result(d_result), .cb(d_cb), .ovf(d_ovf), .zero(d_zero)
    );

    addsub_pipe #(.WIDTH(10), .STAGES(5)) dut10 (
        .clk(clk), .rst(rst), .in_valid(r10_in_valid), .in_ready(r10_in_ready),
        .a(r10_a), .b(r10_b), .op_sub(r10_op_sub), .out_valid(r10_out_valid), .out_ready(r10_out_ready),
        .result(r10_result), .cb(r10_cb), .ovf(r10_ovf), .zero(r10_zero)
    );

    addsub_pipe #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(r32_in_valid), .in_ready(r32_in_ready),
        .a(r32_a), .b(r32_b), .op_sub(r32_op_sub), .out_valid(r32_out_valid), .out_ready(r32_out_ready),
        .result(r32_result), .cb(r32_cb), .ovf(r32_ovf), .zero(r32_zero)
    );

    // Reference: plain integer arithmetic, overflow from operand/result sign comparison.
    function automatic logic [34:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic sub);
        logic [63:0] mask, xx, yy, full, res;
        logic        cout, v;
        mask = (64'd1 << w) - 64'd1;
        xx   = {32'b0, x} & mask;
        yy   = sub ? (~{32'b0, y}) & mask : {32'b0, y} & mask;
        full = xx + yy + {63'b0, sub};
        res  = full & mask;
        cout = full[w];
        v    = (xx[w-1] == yy[w-1]) && (res[w-1] != xx[w-1]);
        return {res[31:0], cout ^ sub, v, (res == 64'd0)};
    endfunction

    // Handshakes are sampled on the falling edge; inputs change just after the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (d_out_valid && d_out_ready) begin
                checks++;
                if (d_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL w16_unexpected: got result=%h, expected no output", d_result);
                end else begin
                    d_e = d_q.pop_front();
                    if ({d_result, d_cb, d_ovf, d_zero} !== d_e) begin
                        failures++;
                        $display("[TB] FAIL w16_beat: got {res,cb,ovf,zero}=%h, expected %h",
                                 {d_result, d_cb, d_ovf, d_zero}, d_e);
                    end
                end
            end
            if (d_in_valid && d_in_ready) d_q.push_back(d_exp);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (r10_out_valid && r10_out_ready) begin
                recv10++;
                checks++;
                if (q10.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL w10_unexpected: got result=%h, expected no output", r10_result);
                end else begin
                    e10 = q10.pop_front();
                    if ({22'b0, r10_result, r10_cb, r10_ovf, r10_zero} !== e10) begin
                        failures++;
                        $display("[TB] FAIL w10_beat: got {res,cb,ovf,zero}=%h, expected %h",
                                 {22'b0, r10_result, r10_cb, r10_ovf, r10_zero}, e10);
                    end
                end
            end
            if (r10_in_valid && r10_in_ready) q10.push_back(r10_exp);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (r32_out_valid && r32_out_ready) begin
                recv32++;
                checks++;
                if (q32.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL w32_unexpected: got result=%h, expected no output", r32_result);
                end else begin
                    e32 = q32.pop_front();
                    if ({r32_result, r32_cb, r32_ovf, r32_zero} !== e32) begin
                        failures++;
                        $display("[TB] FAIL w32_beat: got {res,cb,ovf,zero}=%h, expected %h",
                                 {r32_result, r32_cb, r32_ovf, r32_zero}, e32);
                    end
                end
            end
            if (r32_in_valid && r32_in_ready) q32.push_back(r32_exp);
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic sub,
                        input logic [18:0] e);
        logic got_ready;
        got_ready  = 1'b0;
        d_a        = x;
        d_b        = y;
        d_op_sub   = sub;
        d_exp      = e;
        d_in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (d_in_ready) begin
                got_ready = 1'b1;
                break;
            end
        end
        checks++;
        if (!got_ready) begin
            failures++;
            $display("[TB] FAIL send_accept: in_ready=%b after 100 cycles, expected 1", d_in_ready);
        end
        @(posedge clk);
        #1;
        d_in_valid = 1'b0;
    endtask

    task automatic drain16;
        for (int t = 0; t < 50 && d_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (d_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL w16_drain: %0d beats outstanding, expected 0", d_q.size());
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (d_out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid: got %b, expected 0", d_out_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({d_in_ready, d_out_valid, d_result, d_cb, d_ovf, d_zero} !== {1'b1, 1'b0, 19'b0}) begin
            failures++;
            $display("[TB] FAIL reset_state: got ready=%b valid=%b res=%h flags=%b%b%b, expected ready=1 valid=0 res=0000 flags=000",
                     d_in_ready, d_out_valid, d_result, d_cb, d_ovf, d_zero);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_latency;
        d_out_ready = 1'b1;
        d_a         = 16'h1234;
        d_b         = 16'h0001;
        d_op_sub    = 1'b0;
        d_exp       = {16'h1235, 3'b000};
        d_in_valid  = 1'b1;
        @(negedge clk);
        checks++;
        if (d_in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lat_ready: got in_ready=%b, expected 1", d_in_ready);
        end
        @(posedge clk);
        #1;
        d_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (d_out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lat_early: got out_valid=%b one cycle after accept, expected 0", d_out_valid);
        end
        @(negedge clk);
        checks++;
        if (d_out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lat_due: got out_valid=%b two cycles after accept, expected 1", d_out_valid);
        end
        @(posedge clk);
        #1;
        drain16();
    endtask

    task automatic test_carry_borrow;
        send(16'h0005, 16'h0007, 1'b1, {16'hFFFE, 3'b100});
        send(16'hFFFF, 16'h0001, 1'b0, {16'h0000, 3'b101});
        send(16'h0007, 16'h0005, 1'b1, {16'h0002, 3'b000});
        drain16();
    endtask

    task automatic test_overflow;
        send(16'h7FFF, 16'h0001, 1'b0, {16'h8000, 3'b010});
        send(16'h8000, 16'h0001, 1'b1, {16'h7FFF, 3'b010});
        drain16();
    endtask

    task automatic test_back_to_back;
        logic accepted;
        accepted    = 1'b0;
        d_out_ready = 1'b0;
        send(16'h0100, 16'h0200, 1'b0, {16'h0300, 3'b000});
        send(16'h0010, 16'h0010, 1'b1, {16'h0000, 3'b001});
        d_a        = 16'h8000;
        d_b        = 16'h8000;
        d_op_sub   = 1'b0;
        d_exp      = {16'h0000, 3'b111};
        d_in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({d_in_ready, d_out_valid, d_result, d_cb, d_ovf, d_zero} !== {1'b0, 1'b1, 16'h0300, 3'b000}) begin
                failures++;
                $display("[TB] FAIL stall_hold: cycle %0d got ready=%b valid=%b res=%h flags=%b%b%b, expected ready=0 valid=1 res=0300 flags=000",
                         c, d_in_ready, d_out_valid, d_result, d_cb, d_ovf, d_zero);
            end
            @(posedge clk);
            #1;
        end
        d_out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (d_in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        checks++;
        if (!accepted) begin
            failures++;
            $display("[TB] FAIL stall_release: in_ready=%b after release, expected 1", d_in_ready);
        end
        @(posedge clk);
        #1;
        d_in_valid = 1'b0;
        drain16();
    endtask

    task automatic test_reset_flight;
        int seen;
        seen        = 0;
        d_out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, {16'h3333, 3'b000});
        send(16'h4444, 16'h0004, 1'b1, {16'h4440, 3'b000});
        rst = 1'b1;
        #1;
        checks++;
        if (d_out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flight_rst_valid: got out_valid=%b during reset, expected 0", d_out_valid);
        end
        d_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        d_out_ready = 1'b1;
        #1;
        checks++;
        if (d_in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flight_ready: got in_ready=%b after release, expected 1", d_in_ready);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (d_out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("[TB] FAIL flight_stale: got %0d valid output cycles after reset, expected 0", seen);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        int  sent10, sent32;
        logic acc10, acc32;
        sent10 = 0;
        sent32 = 0;
        for (int cyc = 0; cyc < 60000 && (sent10 < N_RAND || sent32 < N_RAND); cyc++) begin
            @(negedge clk);
            acc10 = r10_in_valid && r10_in_ready;
            acc32 = r32_in_valid && r32_in_ready;
            if (acc10) sent10++;
            if (acc32) sent32++;
            @(posedge clk);
            #1;
            if (acc10 || !r10_in_valid) begin
                r10_in_valid = (sent10 < N_RAND) && ($urandom_range(0, 3) != 0);
                r10_a        = 10'($urandom);
                r10_b        = 10'($urandom);
                r10_op_sub   = 1'($urandom);
                r10_exp      = model(10, {22'b0, r10_a}, {22'b0, r10_b}, r10_op_sub);
            end
            if (acc32 || !r32_in_valid) begin
                r32_in_valid = (sent32 < N_RAND) && ($urandom_range(0, 3) != 0);
                r32_a        = $urandom;
                r32_b        = $urandom;
                r32_op_sub   = 1'($urandom);
                r32_exp      = model(32, r32_a, r32_b, r32_op_sub);
            end
            r10_out_ready = ($urandom_range(0, 3) != 0);
            r32_out_ready = ($urandom_range(0, 3) != 0);
        end
        r10_in_valid  = 1'b0;
        r32_in_valid  = 1'b0;
        r10_out_ready = 1'b1;
        r32_out_ready = 1'b1;
        for (int t = 0; t < 100 && (q10.size() != 0 || q32.size() != 0); t++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (sent10 != N_RAND || recv10 != N_RAND) begin
            failures++;
            $display("[TB] FAIL w10_count: sent=%0d received=%0d, expected %0d each", sent10, recv10, N_RAND);
        end
        checks++;
        if (sent32 != N_RAND || recv32 != N_RAND) begin
            failures++;
            $display("[TB] FAIL w32_count: sent=%0d received=%0d, expected %0d each", sent32, recv32, N_RAND);
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_carry_borrow();
        test_overflow();
        test_back_to_back();
        test_reset_flight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
